soc_simple_gpio: RTL and testbench

Parametrised Avalon-MM GPIO slave. It is the successor to the fixed 8-bit output-only LED PIO in the soc_simple system.
- Adds per-bit direction control.
- Adds atomic set/clear writes.
- Adds synchronised inputs, edge capture and a maskable level interrupt.
- Sits on the soc_simple interconnect as an e_avalon_slave (s1) with zero-wait-state reads.

---
 rtl/soc_simple_gpio_if.sv | 18 +
 rtl/soc_simple_gpio.sv | 110 +++++++++++
 tb/tb_soc_simple_gpio.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/soc_simple_gpio_if.sv
// rtl/soc_simple_gpio_if.sv - Avalon-MM slave bus bundle for the soc_simple GPIO
interface soc_simple_gpio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/soc_simple_gpio.sv
// rtl/soc_simple_gpio.sv - Avalon-MM GPIO with direction, set/clear, edge capture and irq
module soc_simple_gpio #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  soc_simple_gpio_if.slave    bus,
  input  logic [WIDTH-1:0]    in_port,
  output logic [WIDTH-1:0]    out_port,
  output logic [WIDTH-1:0]    oe,
  output logic                irq
);

  localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [2:0]       warm_cnt;
  logic             warm_done;
  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_sel;
  logic [WIDTH-1:0] detected;
  logic [WIDTH-1:0] w1c_mask;
  logic [31:0]      rdata;
  logic             unused;

  assign in_sync   = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_cnt == WARM_MAX);
  assign wr        = bus.chipselect & ~bus.write_n;
  assign wd        = bus.writedata[WIDTH-1:0];
  assign unused    = ^bus.writedata;

  assign rise = in_sync & ~prev;
  assign fall = ~in_sync & prev;

  always_comb begin
    edge_sel = rise;
    if (EDGE_TYPE == 1)
      edge_sel = fall;
    else if (EDGE_TYPE == 2)
      edge_sel = rise | fall;
  end

  // Output-driven bits never capture; nothing captures until the synchroniser has flushed.
  assign detected = warm_done ? (edge_sel & ~dir) : '0;
  assign w1c_mask = (wr && bus.address == 3'd3) ? wd : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev     <= '0;
      warm_cnt <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= in_sync;
      if (!warm_done) warm_cnt <= warm_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE;
      dir      <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      if (wr) begin
        case (bus.address)
          3'd0:    data_out <= wd;
          3'd1:    dir      <= wd;
          3'd2:    irq_mask <= wd;
          3'd4:    data_out <= data_out | wd;
          3'd5:    data_out <= data_out & ~wd;
          default: ;
        endcase
      end
      // A capture in the same cycle as its W1C keeps the bit set.
      edge_cap <= (edge_cap & ~w1c_mask) | detected;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      3'd0:    rdata[WIDTH-1:0] = (dir & data_out) | (~dir & in_sync);
      3'd1:    rdata[WIDTH-1:0] = dir;
      3'd2:    rdata[WIDTH-1:0] = irq_mask;
      3'd3:    rdata[WIDTH-1:0] = edge_cap;
      default: rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;
  assign out_port     = data_out;
  assign oe           = dir;
  assign irq          = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_soc_simple_gpio.sv
// tb/tb_soc_simple_gpio.sv - directed self-checking bench for soc_simple_gpio
module tb_soc_simple_gpio;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in8 = 8'h3C;
  logic [7:0]  out8, oe8;
  logic        irq8;
  logic [31:0] in32 = '0;
  logic [31:0] out32, oe32;
  logic        irq32;
  logic [31:0] v;
  int          checks = 0;
  int          errors = 0;

  soc_simple_gpio_if bus8 ();
  soc_simple_gpio_if bus32 ();

  soc_simple_gpio #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .reset_n(reset_n), .bus(bus8),
    .in_port(in8), .out_port(out8), .oe(oe8), .irq(irq8)
  );

  soc_simple_gpio #(.WIDTH(32), .RESET_VALUE(32'h0), .EDGE_TYPE(2), .SYNC_STAGES(3)) dut32 (
    .clk(clk), .reset_n(reset_n), .bus(bus32),
    .in_port(in32), .out_port(out32), .oe(oe32), .irq(irq32)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic wr8(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus8.address = a; bus8.writedata = d; bus8.chipselect = 1'b1; bus8.write_n = 1'b0;
    @(posedge clk); #1;
    bus8.chipselect = 1'b0; bus8.write_n = 1'b1;
  endtask

  task automatic rd8(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus8.address = a; bus8.chipselect = 1'b1;
    #1 d = bus8.readdata;
    bus8.chipselect = 1'b0;
  endtask

  task automatic wr32(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus32.address = a; bus32.writedata = d; bus32.chipselect = 1'b1; bus32.write_n = 1'b0;
    @(posedge clk); #1;
    bus32.chipselect = 1'b0; bus32.write_n = 1'b1;
  endtask

  task automatic rd32(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus32.address = a; bus32.chipselect = 1'b1;
    #1 d = bus32.readdata;
    bus32.chipselect = 1'b0;
  endtask

  initial begin
    bus8.address = '0;  bus8.chipselect = 1'b0;  bus8.write_n = 1'b1;  bus8.writedata = '0;
    bus32.address = '0; bus32.chipselect = 1'b0; bus32.write_n = 1'b1; bus32.writedata = '0;

    // reset state, pins held at 3C through reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_port", {24'h0, out8}, 32'h000000A5);
    check("rst_oe", {24'h0, oe8}, 32'h0);
    check("rst_irq", {31'h0, irq8}, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(posedge clk);
    rd8(3'd0, v); check("data_in_3c", v, 32'h0000003C);
    rd8(3'd3, v); check("no_warmup_edge", v, 32'h0);

    // direction, data, set/clear
    wr8(3'd1, 32'h0F);
    wr8(3'd0, 32'hFF);
    wr8(3'd5, 32'h03);
    check("outclr_03", {24'h0, out8}, 32'h000000FC);
    wr8(3'd5, 32'hC0);
    wr8(3'd4, 32'h40);
    check("outset_40", {24'h0, out8}, 32'h0000007C);
    check("oe_0f", {24'h0, oe8}, 32'h0000000F);
    @(negedge clk) in8 = 8'hA0;
    repeat (4) @(posedge clk);
    rd8(3'd0, v); check("data_mixed", v, 32'h000000AC);
    rd8(3'd3, v); check("cap_bit7_only", v, 32'h00000080);
    rd8(3'd4, v); check("outset_reads_0", v, 32'h0);
    rd8(3'd5, v); check("outclr_reads_0", v, 32'h0);

    // rising capture latency and irq
    wr8(3'd1, 32'h00);
    wr8(3'd3, 32'hFF);
    wr8(3'd2, 32'h01);
    rd8(3'd2, v); check("irq_mask_rb", v, 32'h00000001);
    @(negedge clk) in8 = 8'hA1;
    @(posedge clk); @(posedge clk);
    rd8(3'd3, v); check("cap_before_lat", v, 32'h0);
    check("irq_before_lat", {31'h0, irq8}, 32'h0);
    rd8(3'd3, v); check("cap_at_lat", v, 32'h00000001);
    check("irq_at_lat", {31'h0, irq8}, 32'h1);
    wr8(3'd3, 32'h01);
    check("irq_after_w1c", {31'h0, irq8}, 32'h0);
    @(negedge clk) in8 = 8'hA0;
    repeat (5) @(posedge clk);
    rd8(3'd3, v); check("no_fall_capture", v, 32'h0);

    // capture coincident with W1C wins
    @(negedge clk) in8 = 8'hA1;
    repeat (4) @(posedge clk);
    @(negedge clk) in8 = 8'hA0;
    repeat (4) @(posedge clk);
    @(negedge clk) in8 = 8'hA1;
    @(posedge clk); @(posedge clk);
    wr8(3'd3, 32'h01);
    rd8(3'd3, v); check("cap_beats_w1c", v, 32'h00000001);
    check("irq_held", {31'h0, irq8}, 32'h1);
    wr8(3'd3, 32'h01);
    rd8(3'd3, v); check("second_w1c", v, 32'h0);
    check("irq_cleared", {31'h0, irq8}, 32'h0);

    // mid-run reset with pins high: no false edge after release
    @(negedge clk) in8 = 8'hFF;
    repeat (4) @(posedge clk);
    @(negedge clk) reset_n = 1'b0;
    #1;
    check("midrst_out_port", {24'h0, out8}, 32'h000000A5);
    check("midrst_oe", {24'h0, oe8}, 32'h0);
    rd8(3'd3, v); check("midrst_cap", v, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    repeat (10) @(posedge clk);
    rd8(3'd3, v); check("held_high_no_edge", v, 32'h0);
    rd8(3'd0, v); check("held_high_data", v, 32'h000000FF);
    @(negedge clk) in8 = 8'hF7;
    repeat (4) @(posedge clk);
    @(negedge clk) in8 = 8'hFF;
    repeat (4) @(posedge clk);
    rd8(3'd3, v); check("bit3_rise", v, 32'h00000008);

    // 32-bit, any-edge, 3-stage synchroniser
    wr32(3'd1, 32'hFFFFFFFF);
    rd32(3'd1, v); check("dir32_full", v, 32'hFFFFFFFF);
    wr32(3'd1, 32'h0);
    @(negedge clk) in32 = 32'h80000000;
    repeat (3) @(posedge clk);
    rd32(3'd3, v); check("cap31_before_lat", v, 32'h0);
    rd32(3'd3, v); check("cap31_rise", v, 32'h80000000);
    wr32(3'd2, 32'h80000000);
    check("irq32_set", {31'h0, irq32}, 32'h1);
    wr32(3'd3, 32'h80000000);
    rd32(3'd3, v); check("cap31_cleared", v, 32'h0);
    @(negedge clk) in32 = 32'h0;
    repeat (5) @(posedge clk);
    rd32(3'd3, v); check("cap31_fall", v, 32'h80000000);
    wr32(3'd6, 32'hFFFFFFFF);
    wr32(3'd7, 32'hFFFFFFFF);
    rd32(3'd6, v); check("rsvd6_read", v, 32'h0);
    rd32(3'd7, v); check("rsvd7_read", v, 32'h0);
    rd32(3'd3, v); check("rsvd_no_w1c", v, 32'h80000000);
    rd32(3'd1, v); check("rsvd_no_dir", v, 32'h0);
    check("rsvd_no_out", out32, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
